// File: rtl/dsp_mac_pipe_if.sv
// Streaming bus of one dsp_mac_pipe slice: sample input, result output, cascade and sticky clear.
// The master drives samples and consumes results; the slave is the MAC slice itself.
interface dsp_mac_pipe_if #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int P_W = 48
);
  localparam int M_W = A_W + B_W + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic signed [A_W-1:0] a;
  logic signed [B_W-1:0] b;
  logic signed [B_W-1:0] d;
  logic signed [P_W-1:0] c;
  logic signed [P_W-1:0] pcin;
  logic [7:0]            opmode;
  logic                  clr_sticky;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [M_W-1:0] m;
  logic signed [P_W-1:0] p;
  logic signed [P_W-1:0] pcout;
  logic                  ovf;
  logic                  ovf_sticky;
  logic                  pat_det;

  modport master (
    output in_valid, a, b, d, c, pcin, opmode, clr_sticky, out_ready,
    input  in_ready, out_valid, m, p, pcout, ovf, ovf_sticky, pat_det
  );

  modport slave (
    input  in_valid, a, b, d, c, pcin, opmode, clr_sticky, out_ready,
    output in_ready, out_valid, m, p, pcout, ovf, ovf_sticky, pat_det
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Three-stage streaming MAC slice: pre-adder -> multiplier -> post-adder/accumulator,
// with per-sample opmode, valid/ready flow control, optional saturation and pattern detect.
module dsp_mac_pipe #(
  parameter int             A_W      = 18,
  parameter int             B_W      = 18,
  parameter int             P_W      = 48,
  parameter int             SAT_EN   = 1,
  parameter logic [P_W-1:0] PATTERN  = '0,
  parameter logic [P_W-1:0] PAT_MASK = '1
) (
  input logic           clk,
  input logic           rst_n,
  dsp_mac_pipe_if.slave bus
);
  localparam int M_W = A_W + B_W + 1;
  localparam int S_W = P_W + 2;

  // Stage 1: captured sample
  logic                  v1_reg;
  logic signed [A_W-1:0] a1_reg;
  logic signed [B_W-1:0] b1_reg;
  logic signed [B_W-1:0] d1_reg;
  logic signed [P_W-1:0] c1_reg;
  logic [7:0]            op1_reg;

  // Stage 2: product plus operands still needed by the post-adder
  logic                  v2_reg;
  logic signed [M_W-1:0] m2_reg;
  logic signed [P_W-1:0] c2_reg;
  logic [7:0]            op2_reg;

  // Stage 3: visible results
  logic                  v3_reg;
  logic signed [M_W-1:0] m_reg;
  logic signed [P_W-1:0] p_reg;
  logic                  ovf_reg;
  logic                  ovf_sticky_reg;

  logic adv;

  logic signed [B_W:0]   b_ext;
  logic signed [B_W:0]   d_ext;
  logic signed [B_W:0]   pre;
  logic signed [M_W-1:0] a_mul;
  logic signed [M_W-1:0] pre_mul;
  logic signed [M_W-1:0] prod;

  logic signed [S_W-1:0] x_ext;
  logic signed [S_W-1:0] z_ext;
  logic signed [S_W-1:0] cin_ext;
  logic signed [S_W-1:0] sum;
  logic                  ovf_next;
  logic signed [P_W-1:0] p_next;

  logic [P_W-1:0]        pat_bit;

  // The whole pipeline stalls only when a finished result is blocked downstream.
  assign adv          = !(v3_reg && !bus.out_ready);
  assign bus.in_ready = adv;

  // Pre-adder works one bit wider than b/d so d+b and d-b never wrap.
  always_comb begin
    b_ext = {b1_reg[B_W-1], b1_reg};
    d_ext = {d1_reg[B_W-1], d1_reg};
    pre   = b_ext;
    if (op1_reg[4]) begin
      pre = op1_reg[5] ? (d_ext - b_ext) : (d_ext + b_ext);
    end
    a_mul   = {{(B_W + 1){a1_reg[A_W-1]}}, a1_reg};
    pre_mul = {{A_W{pre[B_W]}}, pre};
    prod    = a_mul * pre_mul;
  end

  // Post-adder runs two bits wide so 2P and Z-(X+cin) are exact before range checking.
  always_comb begin
    x_ext = '0;
    case (op2_reg[1:0])
      2'b01:   x_ext = {{(S_W - M_W){m2_reg[M_W-1]}}, m2_reg};
      2'b10:   x_ext = {{2{p_reg[P_W-1]}}, p_reg};
      default: x_ext = '0;
    endcase

    z_ext = '0;
    case (op2_reg[3:2])
      2'b01:   z_ext = {{2{c2_reg[P_W-1]}}, c2_reg};
      2'b10:   z_ext = {{2{p_reg[P_W-1]}}, p_reg};
      2'b11:   z_ext = {{2{bus.pcin[P_W-1]}}, bus.pcin};
      default: z_ext = '0;
    endcase

    cin_ext = {{(S_W - 1){1'b0}}, op2_reg[7]};
    sum     = op2_reg[6] ? (z_ext - (x_ext + cin_ext)) : (z_ext + x_ext + cin_ext);

    ovf_next = (sum[S_W-1:P_W-1] != 3'b000) && (sum[S_W-1:P_W-1] != 3'b111);
    p_next   = sum[P_W-1:0];
    if ((SAT_EN != 0) && ovf_next) begin
      p_next = sum[S_W-1] ? {1'b1, {(P_W - 1){1'b0}}} : {1'b0, {(P_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg         <= 1'b0;
      a1_reg         <= '0;
      b1_reg         <= '0;
      d1_reg         <= '0;
      c1_reg         <= '0;
      op1_reg        <= '0;
      v2_reg         <= 1'b0;
      m2_reg         <= '0;
      c2_reg         <= '0;
      op2_reg        <= '0;
      v3_reg         <= 1'b0;
      m_reg          <= '0;
      p_reg          <= '0;
      ovf_reg        <= 1'b0;
      ovf_sticky_reg <= 1'b0;
    end else begin
      if (adv) begin
        v1_reg <= bus.in_valid;
        if (bus.in_valid) begin
          a1_reg  <= bus.a;
          b1_reg  <= bus.b;
          d1_reg  <= bus.d;
          c1_reg  <= bus.c;
          op1_reg <= bus.opmode;
        end

        v2_reg <= v1_reg;
        if (v1_reg) begin
          m2_reg  <= prod;
          c2_reg  <= c1_reg;
          op2_reg <= op1_reg;
        end

        // Bubbles leave p/m/ovf untouched, so accumulation skips them.
        v3_reg <= v2_reg;
        if (v2_reg) begin
          p_reg   <= p_next;
          m_reg   <= m2_reg;
          ovf_reg <= ovf_next;
        end
      end

      if (adv && v2_reg && ovf_next) begin
        ovf_sticky_reg <= 1'b1;
      end else if (bus.clr_sticky) begin
        ovf_sticky_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < P_W; gi++) begin : g_pat
      assign pat_bit[gi] = !PAT_MASK[gi] || (p_reg[gi] == PATTERN[gi]);
    end
  endgenerate

  assign bus.pat_det    = &pat_bit;
  assign bus.out_valid  = v3_reg;
  assign bus.p          = p_reg;
  assign bus.pcout      = p_reg;
  assign bus.m          = m_reg;
  assign bus.ovf        = ovf_reg;
  assign bus.ovf_sticky = ovf_sticky_reg;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: a default-width slice plus two narrow slices (saturating and wrapping).
`timescale 1ns/1ps
module tb_dsp_mac_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  dsp_mac_pipe_if #(.A_W(18), .B_W(18), .P_W(48)) bus0 ();
  dsp_mac_pipe_if #(.A_W(8),  .B_W(8),  .P_W(17)) bus1 ();
  dsp_mac_pipe_if #(.A_W(8),  .B_W(8),  .P_W(17)) bus2 ();

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48), .SAT_EN(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dsp_mac_pipe #(.A_W(8),  .B_W(8),  .P_W(17), .SAT_EN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dsp_mac_pipe #(.A_W(8),  .B_W(8),  .P_W(17), .SAT_EN(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct { logic signed [47:0] p; logic signed [36:0] m; logic ovf; logic st; logic pd; } out0_t;
  typedef struct { logic signed [16:0] p; logic signed [16:0] m; logic ovf; logic st; logic pd; } out1_t;
  out0_t q0[$];
  out1_t q1[$];
  out1_t q2[$];

  // Outputs are recorded mid-cycle, once per accepted result.
  always @(negedge clk) begin
    out0_t t0;
    out1_t t1;
    #1;
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      t0.p = bus0.p; t0.m = bus0.m; t0.ovf = bus0.ovf; t0.st = bus0.ovf_sticky; t0.pd = bus0.pat_det;
      q0.push_back(t0);
      $display("[u0] t=%0t p=%0d m=%0d ovf=%0b sticky=%0b pat=%0b", $time, bus0.p, bus0.m, bus0.ovf, bus0.ovf_sticky, bus0.pat_det);
    end
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      t1.p = bus1.p; t1.m = bus1.m; t1.ovf = bus1.ovf; t1.st = bus1.ovf_sticky; t1.pd = bus1.pat_det;
      q1.push_back(t1);
      $display("[u1] t=%0t p=%0d m=%0d ovf=%0b sticky=%0b", $time, bus1.p, bus1.m, bus1.ovf, bus1.ovf_sticky);
    end
    if (rst_n && bus2.out_valid && bus2.out_ready) begin
      t1.p = bus2.p; t1.m = bus2.m; t1.ovf = bus2.ovf; t1.st = bus2.ovf_sticky; t1.pd = bus2.pat_det;
      q2.push_back(t1);
      $display("[u2] t=%0t p=%0d m=%0d ovf=%0b sticky=%0b", $time, bus2.p, bus2.m, bus2.ovf, bus2.ovf_sticky);
    end
  end

  task automatic issue0(input logic signed [17:0] ia, input logic signed [17:0] ib,
                        input logic signed [17:0] id, input logic signed [47:0] ic,
                        input logic [7:0] iop);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    bus0.a = ia; bus0.b = ib; bus0.d = id; bus0.c = ic; bus0.opmode = iop; bus0.in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      #2 acc = bus0.in_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    #1 bus0.in_valid = 1'b0;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL issue0_accept: in_ready stayed 0, required 1"); end
  endtask

  task automatic issue12(input logic signed [7:0] ia, input logic signed [7:0] ib, input logic [7:0] iop);
    @(negedge clk);
    bus1.a = ia; bus1.b = ib; bus1.opmode = iop; bus1.in_valid = 1'b1;
    bus2.a = ia; bus2.b = ib; bus2.opmode = iop; bus2.in_valid = 1'b1;
    #2;
    n_checks++;
    if (bus1.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue12_accept: in_ready=%b/%b, required 1/1", bus1.in_ready, bus2.in_ready);
    end
    @(posedge clk);
    #1 bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
  endtask

  task automatic wait_q0(input int n);
    int cyc;
    cyc = 0;
    while (q0.size() < n && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++;
    if (q0.size() < n) begin n_fail++; $display("FAIL wait_q0: got %0d outputs, required %0d", q0.size(), n); end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL por_valid: got %b required 0", bus0.out_valid); end
    n_checks++; if (bus0.p !== 48'sd0) begin n_fail++; $display("FAIL por_p: got %0d required 0", bus0.p); end
    n_checks++; if (bus0.pat_det !== 1'b1) begin n_fail++; $display("FAIL por_pat: got %b required 1", bus0.pat_det); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", bus0.in_ready); end
    // Fill the pipe, then drop reset with results in flight.
    issue0(18'sd3, 18'sd5, 18'sd0, 48'sd0, 8'h01);
    issue0(18'sd3, 18'sd5, 18'sd0, 48'sd0, 8'h01);
    issue0(18'sd3, 18'sd5, 18'sd0, 48'sd0, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b required 0", bus0.out_valid); end
    n_checks++; if (bus0.p !== 48'sd0) begin n_fail++; $display("FAIL mid_rst_p: got %0d required 0", bus0.p); end
    n_checks++; if (bus0.m !== 37'sd0) begin n_fail++; $display("FAIL mid_rst_m: got %0d required 0", bus0.m); end
    n_checks++; if (bus0.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sticky: got %b required 0", bus0.ovf_sticky); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (bus0.out_valid !== 1'b0 || q0.size() != 0) begin
      n_fail++; $display("FAIL rst_discard: out_valid=%b outputs=%0d, required 0/0", bus0.out_valid, q0.size());
    end
    q0.delete();
  endtask

  task automatic test_multiply();
    issue0(18'sd3, -18'sd5, 18'sd0, 48'sd0, 8'h01);
    @(negedge clk); #1;
    n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_k1: out_valid=%b required 0", bus0.out_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_k2: out_valid=%b required 0", bus0.out_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_k3: out_valid=%b required 1", bus0.out_valid); end
    n_checks++; if (bus0.p !== -48'sd15) begin n_fail++; $display("FAIL mul_p: got %0d required -15", bus0.p); end
    n_checks++; if (bus0.m !== -37'sd15) begin n_fail++; $display("FAIL mul_m: got %0d required -15", bus0.m); end
    n_checks++; if (bus0.pcout !== -48'sd15) begin n_fail++; $display("FAIL mul_pcout: got %0d required -15", bus0.pcout); end
    n_checks++; if (bus0.ovf !== 1'b0 || bus0.pat_det !== 1'b0) begin
      n_fail++; $display("FAIL mul_flags: ovf=%b pat=%b required 0/0", bus0.ovf, bus0.pat_det);
    end
    wait_q0(1);
    q0.delete();
  endtask

  task automatic test_presub();
    issue0(18'sd2, 18'sd4, 18'sd10, 48'sd0, 8'h31);
    issue0(18'sd2, 18'sd4, 18'sd10, 48'sd0, 8'h11);
    wait_q0(2);
    n_checks++; if (q0[0].p !== 48'sd12) begin n_fail++; $display("FAIL presub_p: got %0d required 12", q0[0].p); end
    n_checks++; if (q0[0].m !== 37'sd12) begin n_fail++; $display("FAIL presub_m: got %0d required 12", q0[0].m); end
    n_checks++; if (q0[1].p !== 48'sd28) begin n_fail++; $display("FAIL preadd_p: got %0d required 28", q0[1].p); end
    q0.delete();
  endtask

  task automatic test_accumulate();
    int exp_p[4] = '{104, 113, 122, 131};
    issue0(18'sd2, 18'sd2, 18'sd0, 48'sd100, 8'h05);
    issue0(18'sd3, 18'sd3, 18'sd0, 48'sd0, 8'h09);
    repeat (2) @(negedge clk);
    issue0(18'sd3, 18'sd3, 18'sd0, 48'sd0, 8'h09);
    issue0(18'sd3, 18'sd3, 18'sd0, 48'sd0, 8'h09);
    wait_q0(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q0[i].p !== 48'(exp_p[i])) begin n_fail++; $display("FAIL acc_p%0d: got %0d required %0d", i, q0[i].p, exp_p[i]); end
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus0.out_valid !== 1'b0 || bus0.p !== 48'sd131) begin
      n_fail++; $display("FAIL acc_hold: out_valid=%b p=%0d required 0/131", bus0.out_valid, bus0.p);
    end
    q0.delete();
  endtask

  task automatic test_edge_cases();
    int exp_p[5] = '{50, 100, 1001, 5, 93};
    issue0(18'sd1, 18'sd50, 18'sd0, 48'sd0, 8'h01);
    issue0(18'sd0, 18'sd0, 18'sd0, 48'sd0, 8'h0A);
    issue0(18'sd1, 18'sd1, 18'sd0, 48'sd0, 8'h0D);
    bus0.pcin = 48'sd1000;
    issue0(18'sd9, 18'sd9, 18'sd0, 48'sd5, 8'h07);
    issue0(18'sd2, 18'sd3, 18'sd0, 48'sd100, 8'hC5);
    wait_q0(5);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (q0[i].p !== 48'(exp_p[i])) begin n_fail++; $display("FAIL edge_p%0d: got %0d required %0d", i, q0[i].p, exp_p[i]); end
    end
    bus0.pcin = 48'sd0;
    q0.delete();
  endtask

  task automatic test_back_to_back();
    int exp_p[6]   = '{-14, -7, 0, 7, 14, 21};
    bit exp_pd[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic signed [47:0] p_hold;
    fork
      begin
        for (int i = 0; i < 6; i++) issue0(18'(i - 2), 18'sd7, 18'sd0, 48'sd0, 8'h01);
      end
      begin
        repeat (4) @(negedge clk);
        bus0.out_ready = 1'b0;
        #1 p_hold = bus0.p;
        n_checks++; if (p_hold !== -48'sd14) begin n_fail++; $display("FAIL bp_first_p: got %0d required -14", p_hold); end
        for (int j = 0; j < 4; j++) begin
          n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b required 0", j, bus0.in_ready); end
          n_checks++; if (bus0.out_valid !== 1'b1 || bus0.p !== p_hold) begin
            n_fail++; $display("FAIL bp_hold%0d: out_valid=%b p=%0d required 1/%0d", j, bus0.out_valid, bus0.p, p_hold);
          end
          if (j < 3) begin @(negedge clk); #1; end
        end
        @(negedge clk);
        bus0.out_ready = 1'b1;
      end
    join
    wait_q0(6);
    n_checks++; if (q0.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d outputs required 6", q0.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (q0[i].p !== 48'(exp_p[i])) begin n_fail++; $display("FAIL bp_p%0d: got %0d required %0d", i, q0[i].p, exp_p[i]); end
      n_checks++; if (q0[i].pd !== exp_pd[i]) begin n_fail++; $display("FAIL bp_pat%0d: got %b required %b", i, q0[i].pd, exp_pd[i]); end
    end
    q0.delete();
  endtask

  task automatic test_saturation();
    int exp_p[5] = '{16129, 32258, 48387, 64516, 65535};
    int cyc;
    for (int i = 0; i < 5; i++) issue12(8'sd127, 8'sd127, 8'h09);
    cyc = 0;
    while ((q1.size() < 5 || q2.size() < 5) && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++; if (q1.size() < 5 || q2.size() < 5) begin
      n_fail++; $display("FAIL sat_wait: got %0d/%0d outputs required 5/5", q1.size(), q2.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (q1[i].p !== 17'(exp_p[i])) begin n_fail++; $display("FAIL sat_p%0d: got %0d required %0d", i, q1[i].p, exp_p[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q2[i].p !== 17'(exp_p[i])) begin n_fail++; $display("FAIL wrap_p%0d: got %0d required %0d", i, q2[i].p, exp_p[i]); end
    end
    n_checks++; if (q2[4].p !== -17'sd50427) begin n_fail++; $display("FAIL wrap_p4: got %0d required -50427", q2[4].p); end
    n_checks++; if (q1[3].ovf !== 1'b0 || q1[3].st !== 1'b0) begin
      n_fail++; $display("FAIL sat_pre_ovf: ovf=%b sticky=%b required 0/0", q1[3].ovf, q1[3].st);
    end
    n_checks++; if (q1[4].ovf !== 1'b1 || q1[4].st !== 1'b1) begin
      n_fail++; $display("FAIL sat_ovf: ovf=%b sticky=%b required 1/1", q1[4].ovf, q1[4].st);
    end
    n_checks++; if (q2[4].ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b required 1", q2[4].ovf); end
    @(negedge clk);
    bus1.clr_sticky = 1'b1;
    @(posedge clk);
    #1 bus1.clr_sticky = 1'b0;
    n_checks++; if (bus1.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clr: got %b required 0", bus1.ovf_sticky); end
    n_checks++; if (bus2.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_keep: got %b required 1", bus2.ovf_sticky); end
    q1.delete();
    q2.delete();
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.d = '0; bus0.c = '0; bus0.pcin = '0;
    bus0.opmode = '0; bus0.clr_sticky = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.d = '0; bus1.c = '0; bus1.pcin = '0;
    bus1.opmode = '0; bus1.clr_sticky = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.d = '0; bus2.c = '0; bus2.pcin = '0;
    bus2.opmode = '0; bus2.clr_sticky = 1'b0; bus2.out_ready = 1'b1;
    test_reset();
    test_multiply();
    test_presub();
    test_accumulate();
    test_edge_cases();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
